// File: rtl/pc_stack_param_pkg.sv
// Shared encodings for the parametrised program-counter stack.
// Stack-op, write-source and overflow-policy codes live here.
package pc_stack_param_pkg;

  typedef enum logic [1:0] {
    PC_STACK_NOP  = 2'd0,
    PC_STACK_PUSH = 2'd1,
    PC_STACK_POP  = 2'd2,
    PC_STACK_RSV  = 2'd3
  } stack_op_e;

  typedef enum logic [1:0] {
    PC_FROM_DATA = 2'd0,
    PC_FROM_REG  = 2'd1,
    PC_FROM_INST = 2'd2,
    PC_FROM_NONE = 2'd3
  } pc_sel_e;

  localparam int OVF_MODE_WRAP = 0;
  localparam int OVF_MODE_SAT  = 1;

endpackage

// File: rtl/pc_stack_param_inc.sv
// One-word ripple incrementer stage.
// Shared across fetch cycles; the caller muxes the word and carry in.
module pc_word_inc #(
  parameter int WORD_W = 4
) (
  input  logic [WORD_W-1:0] word,
  input  logic              carry_in,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out
);

  assign {carry_out, sum} = {1'b0, word}
                          + {{WORD_W{1'b0}}, carry_in};

endmodule

// File: rtl/pc_stack_param.sv
// Parametrised program-counter stack with serial fetch,
// depth tracking and sticky overflow/underflow flags.
module pc_stack_param
  import pc_stack_param_pkg::*;
#(
  parameter int WORD_W     = 4,
  parameter int ADDR_WORDS = 3,
  parameter int DEPTH      = 4,
  parameter int OVF_MODE   = OVF_MODE_WRAP,
  parameter int CYCLE_W    = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CYCLE_W-1:0]           cycle,
  input  logic [1:0]                   control,
  input  logic [1:0]                   pc_next_sel,
  input  logic [WORD_W-1:0]            data,
  input  logic [WORD_W-1:0]            regval,
  input  logic [WORD_W-1:0]            inst_operand,
  input  logic [ADDR_WORDS-1:0]        pc_write_enable,
  input  logic                         clear_flags,
  output logic [WORD_W*ADDR_WORDS-1:0] pc,
  output logic                         pc_enable,
  output logic [WORD_W-1:0]            pc_word,
  output logic [$clog2(DEPTH)-1:0]     depth,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PC_W  = WORD_W * ADDR_WORDS;
  localparam int IDX_W = $clog2(DEPTH);

  logic [PC_W-1:0]       slots [DEPTH];
  logic [PC_W-1:0]       cur;
  logic [PC_W-1:0]       cur_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [IDX_W-1:0]      dep_nxt;
  logic [WORD_W-1:0]     word_cur;
  logic [WORD_W-1:0]     sum;
  logic [WORD_W-1:0]     src;
  logic [ADDR_WORDS-1:0] low;
  logic                  carry;
  logic                  cin;
  logic                  cout;
  logic                  fetch;
  logic                  last;
  logic                  ovf_set;
  logic                  unf_set;
  stack_op_e             op;
  pc_sel_e               sel;

  assign op    = stack_op_e'(control);
  assign sel   = pc_sel_e'(pc_next_sel);
  assign cur   = slots[idx];
  assign pc    = cur;
  assign fetch = cycle < CYCLE_W'(ADDR_WORDS);
  assign last  = cycle == CYCLE_W'(ADDR_WORDS - 1);
  assign cin   = (cycle == '0) ? 1'b1 : carry;

  assign pc_enable = fetch;
  assign pc_word   = fetch ? word_cur : '0;

  always_comb begin
    word_cur = '0;
    for (int i = 0; i < ADDR_WORDS; i++) begin
      if (cycle == CYCLE_W'(i)) begin
        word_cur = cur[i*WORD_W +: WORD_W];
      end
    end
  end

  pc_word_inc #(
    .WORD_W(WORD_W)
  ) u_inc (
    .word     (word_cur),
    .carry_in (cin),
    .sum      (sum),
    .carry_out(cout)
  );

  always_comb begin
    src = '0;
    unique case (sel)
      PC_FROM_DATA: src = data;
      PC_FROM_REG:  src = regval;
      PC_FROM_INST: src = inst_operand;
      PC_FROM_NONE: src = '0;
    endcase
  end

  // Isolate the lowest set strobe bit.
  assign low = pc_write_enable
             & (~pc_write_enable + ADDR_WORDS'(1));

  always_comb begin
    cur_nxt = cur;
    for (int i = 0; i < ADDR_WORDS; i++) begin
      if (fetch && cycle == CYCLE_W'(i)) begin
        cur_nxt[i*WORD_W +: WORD_W] = sum;
      end else if (!fetch && low[i]
                   && sel != PC_FROM_NONE) begin
        cur_nxt[i*WORD_W +: WORD_W] = src;
      end
    end
  end

  always_comb begin
    idx_nxt = idx;
    dep_nxt = depth;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (last) begin
      unique case (1'b1)
        op == PC_STACK_PUSH: begin
          if (depth == IDX_W'(DEPTH - 1)) begin
            ovf_set = 1'b1;
            if (OVF_MODE == OVF_MODE_WRAP) begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            idx_nxt = idx + IDX_W'(1);
            dep_nxt = depth + IDX_W'(1);
          end
        end
        op == PC_STACK_POP: begin
          if (depth == '0) begin
            unf_set = 1'b1;
            if (OVF_MODE == OVF_MODE_WRAP) begin
              idx_nxt = idx - IDX_W'(1);
            end
          end else begin
            idx_nxt = idx - IDX_W'(1);
            dep_nxt = depth - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Slot update uses the old index, so the top-word
  // increment lands before the stack moves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      idx       <= '0;
      depth     <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      slots[idx] <= cur_nxt;
      idx        <= idx_nxt;
      depth      <= dep_nxt;
      carry      <= cout;
      overflow   <= (overflow & ~clear_flags) | ovf_set;
      underflow  <= (underflow & ~clear_flags) | unf_set;
    end
  end

endmodule

// File: tb/tb_pc_stack_param.sv
// Bench for pc_stack_param: directed table, corner sequences,
// and randomized traffic against an arithmetic stack model.
module tb_pc_stack_param;

  localparam int N  = 0;
  localparam int PU = 1;
  localparam int PO = 2;
  localparam int DA = 0;
  localparam int RG = 1;
  localparam int IN = 2;
  localparam int NO = 3;

  logic        clock;
  logic        reset;
  logic [2:0]  cycle;
  logic [1:0]  control;
  logic [1:0]  pc_next_sel;
  logic [3:0]  data;
  logic [3:0]  regval;
  logic [3:0]  inst_operand;
  logic [2:0]  pc_write_enable;
  logic        clear_flags;

  logic [11:0] pc0, pc1;
  logic        en0, en1;
  logic [3:0]  pw0, pw1;
  logic [1:0]  dep0, dep1;
  logic        ov0, ov1, un0, un1;

  int n_vec;
  int n_err;

  pc_stack_param #(.OVF_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .cycle(cycle),
    .control(control), .pc_next_sel(pc_next_sel),
    .data(data), .regval(regval),
    .inst_operand(inst_operand),
    .pc_write_enable(pc_write_enable),
    .clear_flags(clear_flags),
    .pc(pc0), .pc_enable(en0), .pc_word(pw0),
    .depth(dep0), .overflow(ov0), .underflow(un0)
  );

  pc_stack_param #(.OVF_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .cycle(cycle),
    .control(control), .pc_next_sel(pc_next_sel),
    .data(data), .regval(regval),
    .inst_operand(inst_operand),
    .pc_write_enable(pc_write_enable),
    .clear_flags(clear_flags),
    .pc(pc1), .pc_enable(en1), .pc_word(pw1),
    .depth(dep1), .overflow(ov1), .underflow(un1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cyc, ctl, sel, val, we, clr;
    int pc, word, dep, ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int cyc, int ctl, int sel,
                             int val, int we, int clr,
                             int pc, int word, int dep,
                             int ovf, int unf);
    vec_t r;
    r.cyc = cyc; r.ctl = ctl; r.sel = sel;
    r.val = val; r.we = we; r.clr = clr;
    r.pc = pc; r.word = word; r.dep = dep;
    r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int cyc, input int ctl,
                       input int sel, input int val,
                       input int we, input int clr);
    @(negedge clock);
    cycle           = 3'(cyc);
    control         = 2'(ctl);
    pc_next_sel     = 2'(sel);
    pc_write_enable = 3'(we);
    clear_flags     = clr[0];
    data            = 4'(sel == DA || sel == NO ? val : ~val);
    regval          = 4'(sel == RG || sel == NO ? val : ~val);
    inst_operand    = 4'(sel == IN || sel == NO ? val : ~val);
    #2;
  endtask

  task automatic go_idle();
    cycle           = 3'd7;
    control         = 2'd0;
    pc_next_sel     = 2'd3;
    pc_write_enable = 3'd0;
    clear_flags     = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    go_idle();
    reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc0"}, 32'(pc0), 0);
    chk({tag, ".dep0"}, 32'(dep0), 0);
    chk({tag, ".fl0"}, 32'({ov0, un0}), 0);
    chk({tag, ".pc1"}, 32'(pc1), 0);
    chk({tag, ".dep1"}, 32'(dep1), 0);
    chk({tag, ".fl1"}, 32'({ov1, un1}), 0);
  endtask

  // Reference model: one PC per slot as a plain integer.
  int unsigned ms[2][4];
  int unsigned base[2];
  int mi[2], md[2], mo[2], mu[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 4; s++) ms[m][s] = 0;
      base[m] = 0;
      mi[m] = 0; md[m] = 0; mo[m] = 0; mu[m] = 0;
    end
  endtask

  int r_ctl, r_sel, r_we, r_clr, r_d, r_r, r_i;

  task automatic model_step(input int c);
    int unsigned cur, ep, ew, mask, src;
    int en, k;
    logic [11:0] apc;
    logic [3:0]  aw;
    logic        aen, aov, aun;
    logic [1:0]  adep;
    for (int m = 0; m < 2; m++) begin
      apc  = m == 0 ? pc0 : pc1;
      aw   = m == 0 ? pw0 : pw1;
      aen  = m == 0 ? en0 : en1;
      adep = m == 0 ? dep0 : dep1;
      aov  = m == 0 ? ov0 : ov1;
      aun  = m == 0 ? un0 : un1;
      cur = ms[m][mi[m]];
      if (c == 0) base[m] = cur;
      if (c < 3) begin
        mask = (1 << (4 * c)) - 1;
        ep = (base[m] & ~mask & 'hFFF)
           | (((base[m] + 1) & 'hFFF) & mask);
        ew = (base[m] >> (4 * c)) & 'hF;
        en = 1;
      end else begin
        ep = cur; ew = 0; en = 0;
      end
      chk($sformatf("rnd%0d.c%0d.pc", m, c), 32'(apc), ep);
      chk($sformatf("rnd%0d.c%0d.word", m, c), 32'(aw), ew);
      chk($sformatf("rnd%0d.c%0d.en", m, c), 32'(aen), en);
      chk($sformatf("rnd%0d.c%0d.dep", m, c), 32'(adep), md[m]);
      chk($sformatf("rnd%0d.c%0d.ovf", m, c), 32'(aov), mo[m]);
      chk($sformatf("rnd%0d.c%0d.unf", m, c), 32'(aun), mu[m]);
      if (r_clr != 0) begin
        mo[m] = 0; mu[m] = 0;
      end
      if (c == 2) begin
        ms[m][mi[m]] = (base[m] + 1) & 'hFFF;
        if (r_ctl == PU) begin
          if (md[m] == 3) begin
            mo[m] = 1;
            if (m == 0) mi[m] = (mi[m] + 1) % 4;
          end else begin
            mi[m] = (mi[m] + 1) % 4; md[m]++;
          end
        end else if (r_ctl == PO) begin
          if (md[m] == 0) begin
            mu[m] = 1;
            if (m == 0) mi[m] = (mi[m] + 3) % 4;
          end else begin
            mi[m] = (mi[m] + 3) % 4; md[m]--;
          end
        end
      end
      if (c >= 3 && r_we != 0 && r_sel != NO) begin
        k   = r_we[0] ? 0 : (r_we[1] ? 1 : 2);
        src = r_sel == DA ? r_d : (r_sel == RG ? r_r : r_i);
        ms[m][mi[m]] = (cur & ~(32'hF << (4 * k)))
                     | (src << (4 * k));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    data = '0; regval = '0; inst_operand = '0;
    go_idle();

    // Held in reset: outputs stay zero, enable tracks cycle.
    for (int c = 0; c < 8; c++) begin
      apply(c, PU, DA, 'hF, 1, 0);
      chk($sformatf("rst.c%0d.pc", c), 32'(pc0), 0);
      chk($sformatf("rst.c%0d.word", c), 32'(pw0), 0);
      chk($sformatf("rst.c%0d.en", c), 32'(en0), c < 3);
      chk($sformatf("rst.c%0d.dep", c), 32'(dep0), 0);
    end
    release_reset();

    tbl.push_back(v(0,N,NO,0,0,0,'h000,0,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h001,0,0,0,0));
    tbl.push_back(v(2,N,NO,0,0,0,'h001,0,0,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h001,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h001,1,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h002,0,0,0,0));
    tbl.push_back(v(2,N,NO,0,0,0,'h002,0,0,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h002,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h002,2,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h003,0,0,0,0));
    tbl.push_back(v(2,N,NO,0,0,0,'h003,0,0,0,0));
    tbl.push_back(v(3,N,IN,15,1,0,'h003,0,0,0,0));
    tbl.push_back(v(4,N,IN,15,2,0,'h00F,0,0,0,0));
    tbl.push_back(v(5,N,IN,0,4,0,'h0FF,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h0FF,15,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h0F0,15,0,0,0));
    tbl.push_back(v(2,N,NO,0,0,0,'h000,0,0,0,0));
    tbl.push_back(v(3,N,IN,15,7,0,'h100,0,0,0,0));
    tbl.push_back(v(4,N,IN,15,6,0,'h10F,0,0,0,0));
    tbl.push_back(v(5,N,RG,15,4,0,'h1FF,0,0,0,0));
    tbl.push_back(v(6,N,NO,0,4,0,'hFFF,0,0,0,0));
    tbl.push_back(v(7,N,NO,0,0,0,'hFFF,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'hFFF,15,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'hFF0,15,0,0,0));
    tbl.push_back(v(2,N,NO,0,0,0,'hF00,15,0,0,0));
    tbl.push_back(v(3,N,DA,3,1,0,'h000,0,0,0,0));
    tbl.push_back(v(4,N,DA,2,2,0,'h003,0,0,0,0));
    tbl.push_back(v(5,N,DA,1,4,0,'h023,0,0,0,0));
    tbl.push_back(v(6,N,NO,0,0,0,'h123,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h123,3,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h124,2,0,0,0));
    tbl.push_back(v(2,PU,NO,0,0,0,'h124,1,0,0,0));
    tbl.push_back(v(3,N,IN,6,1,0,'h000,0,1,0,0));
    tbl.push_back(v(4,N,IN,5,2,0,'h006,0,1,0,0));
    tbl.push_back(v(5,N,IN,4,4,0,'h056,0,1,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h456,6,1,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h457,5,1,0,0));
    tbl.push_back(v(2,PO,NO,0,0,0,'h457,4,1,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h124,0,0,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h124,4,0,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h125,2,0,0,0));
    tbl.push_back(v(2,PU,NO,0,0,0,'h125,1,0,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h457,0,1,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h457,7,1,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h458,5,1,0,0));
    tbl.push_back(v(2,PU,NO,0,0,0,'h458,4,1,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h000,0,2,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h000,0,2,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h001,0,2,0,0));
    tbl.push_back(v(2,PU,NO,0,0,0,'h001,0,2,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h000,0,3,0,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h000,0,3,0,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h001,0,3,0,0));
    tbl.push_back(v(2,PU,NO,0,0,0,'h001,0,3,0,0));
    tbl.push_back(v(3,N,NO,0,0,0,'h125,0,3,1,0));
    tbl.push_back(v(0,N,NO,0,0,0,'h125,5,3,1,0));
    tbl.push_back(v(1,N,NO,0,0,0,'h126,2,3,1,0));
    tbl.push_back(v(2,PU,NO,0,0,1,'h126,1,3,1,0));
    tbl.push_back(v(3,N,NO,0,0,1,'h458,0,3,1,0));
    tbl.push_back(v(4,N,NO,0,0,0,'h458,0,3,0,0));

    foreach (tbl[i]) begin
      apply(tbl[i].cyc, tbl[i].ctl, tbl[i].sel,
            tbl[i].val, tbl[i].we, tbl[i].clr);
      chk($sformatf("t%0d.pc", i), 32'(pc0), tbl[i].pc);
      chk($sformatf("t%0d.word", i), 32'(pw0), tbl[i].word);
      chk($sformatf("t%0d.en", i), 32'(en0), tbl[i].cyc < 3);
      chk($sformatf("t%0d.dep", i), 32'(dep0), tbl[i].dep);
      chk($sformatf("t%0d.ovf", i), 32'(ov0), tbl[i].ovf);
      chk($sformatf("t%0d.unf", i), 32'(un0), tbl[i].unf);
    end

    // Pop at depth 0: saturate holds the slot, wrap moves to slot 3.
    @(negedge clock);
    reset = 1'b0;
    release_reset();
    apply(0, N, NO, 0, 0, 0);
    apply(1, N, NO, 0, 0, 0);
    apply(2, PO, NO, 0, 0, 0);
    apply(3, N, NO, 0, 0, 0);
    chk("sat.pc", 32'(pc1), 'h001);
    chk("sat.unf", 32'(un1), 1);
    chk("sat.dep", 32'(dep1), 0);
    chk("wrap.pc", 32'(pc0), 'h000);
    chk("wrap.unf", 32'(un0), 1);
    chk("wrap.dep", 32'(dep0), 0);

    // Async reset in the middle of fetch cycle 1.
    apply(0, N, NO, 0, 0, 0);
    apply(1, N, NO, 0, 0, 0);
    apply(2, PU, NO, 0, 0, 0);
    apply(3, N, NO, 0, 0, 0);
    apply(0, N, NO, 0, 0, 0);
    apply(1, N, NO, 0, 0, 0);
    chk("mid.pre_pc", 32'(pc0), 'h002);
    chk("mid.pre_dep", 32'(dep1), 1);
    reset = 1'b0;
    #1;
    chk_zero("mid");
    release_reset();

    model_reset();
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clock);
        go_idle();
        #2 reset = 1'b0;
        #1 chk_zero($sformatf("rrst%0d", s));
        model_reset();
        release_reset();
      end
      for (int c = 0; c < 8; c++) begin
        r_ctl = $urandom_range(0, 3);
        r_sel = $urandom_range(0, 3);
        r_we  = $urandom_range(0, 7);
        r_clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
        r_d   = $urandom_range(0, 15);
        r_r   = $urandom_range(0, 15);
        r_i   = $urandom_range(0, 15);
        @(negedge clock);
        cycle           = 3'(c);
        control         = 2'(r_ctl);
        pc_next_sel     = 2'(r_sel);
        pc_write_enable = 3'(r_we);
        clear_flags     = r_clr[0];
        data            = 4'(r_d);
        regval          = 4'(r_r);
        inst_operand    = 4'(r_i);
        #2;
        model_step(c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_stack_param.md
Name: pc_stack_param

Overview:
- Parametrised successor of the 4-slot, 12-bit program-counter stack.
- Holds DEPTH program counters of ADDR_WORDS nibbles each.
- Serialises the active PC onto the nibble bus during fetch cycles, incrementing it with a rippled carry.
- Performs push/pop at the end of fetch and accepts nibble-wise jump writes in later cycles.
- New over the previous block: tracked stack depth, sticky overflow/underflow flags, selectable wrap/saturate policy, defined behaviour for illegal select codes.

Parameters:
- WORD_W, 4: width of one bus word/nibble.
- ADDR_WORDS, 3: words per PC; PC width = WORD_W*ADDR_WORDS.
- DEPTH, 4: number of PC slots; power of two, at least 2.
- OVF_MODE, 0: 0 = WRAP (index moves modulo DEPTH, oldest entry lost); 1 = SATURATE (offending push/pop ignored).
- CYCLE_W, 3: width of cycle input; requires ADDR_WORDS < 2**CYCLE_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cycle  in  CYCLE_W  instruction-cycle number from the timing generator.
- control  in  2  stack op: NOP / PUSH / POP; code 3 treated as NOP.
- pc_next_sel  in  2  write source: DATA / REG / INST; code 3 = no write.
- data  in  WORD_W  data-bus word.
- regval  in  WORD_W  register-file word.
- inst_operand  in  WORD_W  immediate operand word.
- pc_write_enable  in  ADDR_WORDS  per-word write strobe; bit k targets word k.
- clear_flags  in  1  synchronous clear of overflow/underflow.
- pc  out  WORD_W*ADDR_WORDS  current slot contents.
- pc_enable  out  1  high while pc_word drives the bus.
- pc_word  out  WORD_W  serialised PC word.
- depth  out  clog2(DEPTH)  number of pushed return addresses, 0..DEPTH-1.
- overflow  out  1  sticky: push attempted at full depth.
- underflow  out  1  sticky: pop attempted at depth 0.

Behaviour:
- Reset (async, active-low): all slots, index, carry, depth, overflow and underflow go to 0 immediately, including mid-cycle.
- Reset state: pc=0. pc_word=0 in every cycle. pc_enable follows cycle, since it is combinational.
- Fetch cycles k = 0..ADDR_WORDS-1:
  - pc_word = word k of slot[index]; pc_enable = 1; both combinational, zero latency.
  - On the clock edge, word k <= word k + (k==0 ? 1 : carry) and carry <= carry-out.
  - Carry out of the top word is discarded, so the all-ones PC wraps to 0.
- Cycle ADDR_WORDS-1, same edge as the top-word increment, which targets the old index:
  - PUSH with depth < DEPTH-1: index+1, depth+1.
  - POP with depth > 0: index-1, depth-1.
  - PUSH at depth == DEPTH-1: overflow <= 1. WRAP: index+1 mod DEPTH, depth unchanged. SATURATE: index unchanged.
  - POP at depth 0: underflow <= 1. WRAP: index-1 mod DEPTH, depth unchanged. SATURATE: index unchanged.
  - The newly selected slot keeps its prior contents; the jump target is loaded by later writes.
- Cycles >= ADDR_WORDS:
  - pc_enable = 0; pc_word = 0.
  - If pc_write_enable != 0 and pc_next_sel is legal, only the lowest set bit k writes: word k of slot[index] <= selected source.
  - Multiple set bits: lowest wins; the others are ignored that cycle.
- pc_write_enable and control are ignored outside their cycle windows.
- clear_flags zeroes both flags on the edge. A flag-setting event on the same edge wins (flag = 1).
- The carry register is used only within the fetch window; its value outside that window is irrelevant.

Decomposition:
- Shared header pc_stack.vh (extended) holds:
  - PC_STACK_NOP/PUSH/POP
  - PC_FROM_DATA/REG/INST/NONE
  - OVF_MODE_WRAP/SAT
- One sub-module, pc_word_inc: WORD_W-bit word + carry_in giving sum and carry_out. It is instantiated once and muxed by cycle.

Test Plan:
- Reset, then 3 fetch sequences (cycles 0..7), NOP: pc_word reads 0,0,0 then 1,0,0 then 2,0,0; final pc=0x003.
- Preload pc=0x0FF via writes (INST, strobes 001/010/100), then fetch: emits F,F,0; pc becomes 0x100. Preload 0xFFF, fetch: pc wraps to 0x000.
- PUSH on cycle 2 at pc=0x123:
  - slot0 = 0x124; index=1; depth=1.
  - Write 0x456 in cycles 3..5; POP next fetch: pc returns to slot0 = 0x124 after increment sequence; depth=0.
- OVF_MODE=0, DEPTH=4: 4 PUSHes → depth 3 then stays 3, overflow=1, index wrapped to 0. clear_flags with a concurrent 5th PUSH: overflow stays 1.
- OVF_MODE=1: POP at depth 0 → underflow=1, index 0, pc unchanged.
- Assert reset mid cycle 1 after a PUSH: pc, depth and flags read 0 before the next edge. pc_write_enable=3'b110, pc_next_sel=3: no slot changes.
